// File: rtl/cf_fft_pkg.sv
// ============================================================================
//  Module      : cf_fft_pkg
//  Description : Shared constants and fixed-point helpers for the 1024-point
//                FFT pipeline: block size, word layout of a packed complex
//                sample (re = upper half, im = lower half, both Q1.15), and
//                the rounding / saturation used after every Q1.15 product.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cf_fft_pkg;

    localparam int c_n  = 256;          // points per butterfly block
    localparam int c_aw = 8;            // log2(c_n)
    localparam int c_dw = 32;           // packed complex word
    localparam int c_qw = 16;           // one Q1.15 component

    // Field positions inside a packed complex word
    localparam int c_re_lsb = 16;
    localparam int c_im_lsb = 0;

    // Twiddle generation (elaboration time only)
    localparam real c_pi       = 3.141592653589793;
    localparam real c_tw_scale = 32767.0;

    function automatic logic signed [c_qw-1:0] re_of(input logic [c_dw-1:0] w);
        return w[c_re_lsb +: c_qw];
    endfunction

    function automatic logic signed [c_qw-1:0] im_of(input logic [c_dw-1:0] w);
        return w[c_im_lsb +: c_qw];
    endfunction

    // (p + 2^14) >>> 15 : round-half-up back to Q1.15, keeping two guard bits
    // so the saturation stage can see any overflow.
    function automatic logic signed [c_qw+1:0] round_q15(input logic signed [2*c_qw:0] p);
        logic signed [2*c_qw:0] t;
        t = p + 33'sd16384;
        return t[2*c_qw:c_qw-1];
    endfunction

    function automatic logic [c_qw-1:0] sat_q15(input logic signed [c_qw+1:0] v);
        if (v > 18'sd32767) begin
            return 16'h7FFF;
        end else if (v < -18'sd32768) begin
            return 16'h8000;
        end
        return v[c_qw-1:0];
    endfunction

    // Nearest-integer conversion, ties away from zero
    function automatic int q15_from_real(input real x);
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(0.5 - x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cf_fft_1024_8_tw.sv
// ============================================================================
//  Module      : cf_fft_1024_8_tw
//  Description : Synchronous twiddle ROM, W^k = exp(-j*2*pi*k/N) for
//                k = 0..N/2-1, Q1.15, contents built at elaboration.
//  Ports       : clock_c  - clock
//                ce       - clock enable; the output register only loads on ce
//                i_k      - twiddle index k
//                o_w      - {wr, wi}, valid one ce edge after i_k
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cf_fft_1024_8_tw
    import cf_fft_pkg::*;
#(
    parameter int N  = c_n,
    parameter int AW = c_aw,
    parameter int DW = c_dw
)(
    input  logic          clock_c,
    input  logic          ce,
    input  logic [AW-2:0] i_k,
    output logic [DW-1:0] o_w
);

    logic [DW-1:0] w_rom [0:N/2-1];

    // Scale is 32767 so that cos(0) lands on 0x7FFF and -sin(pi/2) on 0x8001
    // without needing a clamp.
    for (genvar g = 0; g < N/2; g++) begin : g_rom
        localparam real c_ang = 2.0 * c_pi * real'(g) / real'(N);
        localparam int  c_wr  = q15_from_real(c_tw_scale * $cos(c_ang));
        localparam int  c_wi  = q15_from_real(-c_tw_scale * $sin(c_ang));
        assign w_rom[g] = {c_wr[c_qw-1:0], c_wi[c_qw-1:0]};
    end

    always_ff @(posedge clock_c) begin
        if (ce) begin
            o_w <= w_rom[i_k];
        end
    end

endmodule

`default_nettype wire

// File: rtl/cf_fft_1024_8_bf.sv
// ============================================================================
//  Module      : cf_fft_1024_8_bf
//  Description : Radix-2 DIF single-path delay-feedback butterfly for
//                256-point blocks. Sample k is paired with sample k+128;
//                the sum path a goes to address k, the twiddled difference
//                b = d*W^k goes to address 128+k one block later.
//  Ports       : clock_c  - clock (rising edge)
//                reset_n  - synchronous active-low reset
//                ce       - clock enable for all state
//                sync     - marks the sample at index 0 of a block
//                i_data   - input sample {re, im} Q1.15
//                o_we     - write strobe for the reorder buffer
//                o_addr   - destination index 0..255
//                o_data   - result {re, im} Q1.15
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cf_fft_1024_8_bf
    import cf_fft_pkg::*;
#(
    parameter int N  = c_n,
    parameter int AW = c_aw,
    parameter int DW = c_dw
)(
    input  logic          clock_c,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          sync,
    input  logic [DW-1:0] i_data,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data
);

    localparam int c_kw = AW - 1;       // index within a half block
    localparam int c_pw = 2 * c_qw;     // full Q1.15 x Q1.15 product

    // ------------------------------------------------------------------
    // Index counter and block state
    // ------------------------------------------------------------------
    logic [AW-1:0]   r_n;
    logic            r_primed;
    logic [AW-1:0]   w_idx;
    logic            w_half;
    logic [c_kw-1:0] w_k;
    logic            w_abort;
    logic            w_last;

    // sync overrides the counter for the current sample itself
    assign w_idx   = sync ? '0 : r_n;
    assign w_half  = w_idx[AW-1];
    assign w_k     = w_idx[c_kw-1:0];
    assign w_abort = sync && (r_n != '0);
    assign w_last  = w_half && (w_k == {c_kw{1'b1}});

    always_ff @(posedge clock_c) begin
        if (!reset_n) begin
            r_n      <= '0;
            r_primed <= 1'b0;
        end else if (ce) begin
            r_n <= w_idx + AW'(1);
            if (w_abort) begin
                r_primed <= 1'b0;
            end else if (w_last) begin
                r_primed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Delay RAM with read-before-write at k; the read is asynchronous so the
    // difference can be written back in the same cycle.
    // ------------------------------------------------------------------
    logic [DW-1:0]          r_mem [0:N/2-1];
    logic [DW-1:0]          w_x;
    logic signed [c_qw-1:0] w_xr, w_xi, w_ir, w_ii;
    logic signed [c_qw:0]   w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic [DW-1:0]          w_a;
    logic [DW-1:0]          w_d;
    logic [DW-1:0]          w_ram_wd;

    assign w_x  = r_mem[w_k];
    assign w_xr = re_of(w_x);
    assign w_xi = im_of(w_x);
    assign w_ir = re_of(i_data);
    assign w_ii = im_of(i_data);

    assign w_sum_re = {w_xr[c_qw-1], w_xr} + {w_ir[c_qw-1], w_ir};
    assign w_sum_im = {w_xi[c_qw-1], w_xi} + {w_ii[c_qw-1], w_ii};
    assign w_dif_re = {w_xr[c_qw-1], w_xr} - {w_ir[c_qw-1], w_ir};
    assign w_dif_im = {w_xi[c_qw-1], w_xi} - {w_ii[c_qw-1], w_ii};

    // Dropping bit 0 of the 17-bit result is the floor halving
    assign w_a = {w_sum_re[c_qw:1], w_sum_im[c_qw:1]};
    assign w_d = {w_dif_re[c_qw:1], w_dif_im[c_qw:1]};

    assign w_ram_wd = w_half ? w_d : i_data;

    always_ff @(posedge clock_c) begin
        if (ce) begin
            r_mem[w_k] <= w_ram_wd;
        end
    end

    // ------------------------------------------------------------------
    // Twiddle ROM, aligned with pipeline stage 1
    // ------------------------------------------------------------------
    logic [DW-1:0] w_tw;

    cf_fft_1024_8_tw #(
        .N  (N),
        .AW (AW),
        .DW (DW)
    ) u_tw (
        .clock_c (clock_c),
        .ce      (ce),
        .i_k     (w_k),
        .o_w     (w_tw)
    );

    // ------------------------------------------------------------------
    // Pipeline: s1 operand capture, s2 partial products, s3 product sums,
    // then output register. The a value rides alongside unchanged so both
    // paths leave after the same number of ce edges.
    // ------------------------------------------------------------------
    logic                   r1_v, r2_v, r3_v;
    logic                   r1_half, r2_half, r3_half;
    logic [c_kw-1:0]        r1_k, r2_k, r3_k;
    logic [DW-1:0]          r1_data, r2_a, r3_a;
    logic signed [c_qw-1:0] w_dr, w_di, w_tr, w_ti;
    logic signed [c_pw-1:0] r2_rr, r2_ii, r2_ri, r2_ir;
    logic signed [c_pw:0]   r3_re, r3_im;

    assign w_dr = re_of(r1_data);
    assign w_di = im_of(r1_data);
    assign w_tr = re_of(w_tw);
    assign w_ti = im_of(w_tw);

    always_ff @(posedge clock_c) begin
        if (!reset_n) begin
            r1_v <= 1'b0;
            r2_v <= 1'b0;
            r3_v <= 1'b0;
        end else if (ce) begin
            // first-half slots only carry a b result once a full d block exists
            r1_v <= w_half || (r_primed && !w_abort);
            r2_v <= r1_v;
            r3_v <= r2_v;
        end
    end

    always_ff @(posedge clock_c) begin
        if (ce) begin
            r1_data <= w_half ? w_a : w_x;
            r1_half <= w_half;
            r1_k    <= w_k;

            r2_rr   <= c_pw'(w_dr) * c_pw'(w_tr);
            r2_ii   <= c_pw'(w_di) * c_pw'(w_ti);
            r2_ri   <= c_pw'(w_dr) * c_pw'(w_ti);
            r2_ir   <= c_pw'(w_di) * c_pw'(w_tr);
            r2_a    <= r1_data;
            r2_half <= r1_half;
            r2_k    <= r1_k;

            r3_re   <= (c_pw+1)'(r2_rr) - (c_pw+1)'(r2_ii);
            r3_im   <= (c_pw+1)'(r2_ri) + (c_pw+1)'(r2_ir);
            r3_a    <= r2_a;
            r3_half <= r2_half;
            r3_k    <= r2_k;
        end
    end

    // ------------------------------------------------------------------
    // Output registers: a goes to k, b goes to 128+k
    // ------------------------------------------------------------------
    always_ff @(posedge clock_c) begin
        if (!reset_n) begin
            o_we   <= 1'b0;
            o_addr <= '0;
            o_data <= '0;
        end else if (ce) begin
            o_we <= r3_v;
            if (r3_v) begin
                o_addr <= {~r3_half, r3_k};
                o_data <= r3_half ? r3_a
                                  : {sat_q15(round_q15(r3_re)), sat_q15(round_q15(r3_im))};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cf_fft_1024_8_bf.sv
// ============================================================================
//  Module      : tb_cf_fft_1024_8_bf
//  Description : Scoreboard bench for cf_fft_1024_8_bf. A block-level
//                reference (sums, halved differences, complex twiddle
//                products) queues the expected write for every accepted
//                sample; a monitor compares each ce edge's output.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cf_fft_1024_8_bf;

    logic        clock_c = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce      = 1'b0;
    logic        sync    = 1'b0;
    logic [31:0] i_data  = '0;
    logic        o_we;
    logic [7:0]  o_addr;
    logic [31:0] o_data;

    always #5 clock_c = ~clock_c;

    cf_fft_1024_8_bf dut (
        .clock_c (clock_c),
        .reset_n (reset_n),
        .ce      (ce),
        .sync    (sync),
        .i_data  (i_data),
        .o_we    (o_we),
        .o_addr  (o_addr),
        .o_data  (o_data)
    );

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: twiddles, current block's first half, last full d block
    int tw_re[128], tw_im[128];
    int m_n;
    bit m_primed;
    int bx_re[128], bx_im[128];
    int dn_re[128], dn_im[128];
    int dp_re[128], dp_im[128];

    function automatic int qround(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [15:0] q15(input longint p);
        longint r;
        r = (p + 16384) >>> 15;
        if (r > 32767) return 16'h7FFF;
        if (r < -32768) return 16'h8000;
        return r[15:0];
    endfunction

    task automatic push(input bit we, input int addr, input logic [31:0] data);
        exp_t e;
        e.we   = we;
        e.addr = addr[7:0];
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input logic [31:0] x, input bit s);
        int     k, xr, xi, ar, ai;
        longint pr, pi;
        xr = s16(x[31:16]);
        xi = s16(x[15:0]);
        if (s) begin
            if (m_n != 0) m_primed = 1'b0;
            m_n = 0;
        end
        k = m_n % 128;
        if (m_n < 128) begin
            if (m_primed) begin
                pr = longint'(dp_re[k]) * tw_re[k] - longint'(dp_im[k]) * tw_im[k];
                pi = longint'(dp_re[k]) * tw_im[k] + longint'(dp_im[k]) * tw_re[k];
                push(1'b1, 128 + k, {q15(pr), q15(pi)});
            end else begin
                push(1'b0, 0, 32'h0);
            end
            bx_re[k] = xr;
            bx_im[k] = xi;
        end else begin
            ar = (bx_re[k] + xr) >>> 1;
            ai = (bx_im[k] + xi) >>> 1;
            push(1'b1, k, {ar[15:0], ai[15:0]});
            dn_re[k] = (bx_re[k] - xr) >>> 1;
            dn_im[k] = (bx_im[k] - xi) >>> 1;
            if (k == 127) begin
                dp_re    = dn_re;
                dp_im    = dn_im;
                m_primed = 1'b1;
            end
        end
        m_n = (m_n + 1) % 256;
    endtask

    task automatic send(input logic [31:0] x, input bit s);
        @(negedge clock_c);
        ce     = 1'b1;
        sync   = s;
        i_data = x;
        model_step(x, s);
    endtask

    task automatic idle();
        @(negedge clock_c);
        ce     = 1'b0;
        sync   = 1'($urandom_range(0, 1));
        i_data = $urandom;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock_c);
        reset_n = 1'b0;
        ce      = 1'b1;
        sync    = 1'b0;
        i_data  = $urandom;
        exp_q.delete();
        m_n      = 0;
        m_primed = 1'b0;
        // pipeline is empty after reset: three silent ce edges before data
        repeat (3) push(1'b0, 0, 32'h0);
        repeat (cycles - 1) @(negedge clock_c);
        @(negedge clock_c);
        reset_n = 1'b1;
        ce      = 1'b0;
    endtask

    // Monitor: one comparison per clock edge
    initial begin
        logic [40:0] prev;
        logic [40:0] cur;
        exp_t        e;
        prev = '0;
        forever begin
            @(posedge clock_c);
            #1;
            cur = {o_we, o_addr, o_data};
            n_checks++;
            if (!reset_n) begin
                if (cur == '0) n_pass++;
                else $display("FAIL reset_state: got we=%0b addr=%0d data=%h, required we=0 addr=0 data=00000000",
                              o_we, o_addr, o_data);
            end else if (!ce) begin
                if (cur == prev) n_pass++;
                else $display("FAIL hold: got we=%0b addr=%0d data=%h, required held we=%0b addr=%0d data=%h",
                              o_we, o_addr, o_data, prev[40], prev[39:32], prev[31:0]);
            end else if (exp_q.size() == 0) begin
                $display("FAIL underrun: got we=%0b addr=%0d data=%h with no expected entry",
                         o_we, o_addr, o_data);
            end else begin
                e = exp_q.pop_front();
                if (!e.we) begin
                    if (o_we == 1'b0) n_pass++;
                    else $display("FAIL idle_slot: got we=1 addr=%0d data=%h, required we=0",
                                  o_addr, o_data);
                end else begin
                    if (o_we && o_addr == e.addr && o_data == e.data) n_pass++;
                    else $display("FAIL write: got we=%0b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                                  o_we, o_addr, o_data, e.addr, e.data);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 128; k++) begin
            tw_re[k] = qround(32767.0 * $cos(2.0 * 3.141592653589793 * k / 256.0));
            tw_im[k] = qround(-32767.0 * $sin(2.0 * 3.141592653589793 * k / 256.0));
        end

        do_reset(3);

        // constant block, then impulse at 0, impulse at 64, full scale
        for (int i = 0; i < 256; i++) send(32'h0100_0000, i == 0);
        for (int i = 0; i < 256; i++) send((i == 0) ? 32'h4000_0000 : 32'h0, i == 0);
        for (int i = 0; i < 256; i++) send((i == 64) ? 32'h4000_0000 : 32'h0, i == 0);
        for (int i = 0; i < 256; i++) send((i < 128) ? 32'h7FFF_8000 : 32'h8000_7FFF, i == 0);

        // random data, continuous ce
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) send($urandom, i == 0);

        // random data, ce gaps (sync toggling while ce=0 must be ignored)
        for (int i = 0; i < 512; i++) begin
            repeat ($urandom_range(0, 2)) idle();
            send($urandom, (i % 256) == 0);
        end

        // mid-block sync at n=77, then reset at n=200 of the new block
        for (int i = 0; i < 77; i++) send($urandom, i == 0);
        for (int i = 0; i < 200; i++) send($urandom, i == 0);
        do_reset(2);
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 256; i++) send($urandom, i == 0);

        // flush the last three results without queuing new ones
        repeat (3) begin
            @(negedge clock_c);
            ce     = 1'b1;
            sync   = 1'b0;
            i_data = '0;
        end
        @(negedge clock_c);
        ce = 1'b0;
        repeat (4) @(negedge clock_c);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d outstanding expected writes, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
